frame_update_sequencer: RTL and testbench

//  Consumer end of the refresh tick: turns each one-cycle refresh pulse into a req/done handshake

---
 rtl/frame_seq_pkg.sv | 10 +
 rtl/frame_update_sequencer_sat_counter.sv | 19 +
 rtl/frame_update_sequencer.sv | 122 ++++++++++++
 tb/tb_frame_update_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types and clocking-derived defaults for the frame update sequencer.
package frame_seq_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} frame_seq_state_t;

  localparam int unsigned CLK_HZ                 = 50_000_000;
  localparam int unsigned REFRESH_HZ             = 60;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = CLK_HZ / REFRESH_HZ;

endpackage

// File: rtl/frame_update_sequencer_sat_counter.sv
// Up-counter with synchronous active-low clear that holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/frame_update_sequencer.sv
// Turns refresh ticks into a req/done handshake, buffering one tick and counting drops.
// Optional watchdog abort when FRAME_UPDATE_WATCHDOG_EN is defined (adds timeout_pulse).
module frame_update_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W    = 16,
  parameter int unsigned OVR_CNT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   clk_50,
  input  logic                   rst_n,
  input  logic                   refresh_tick,
  input  logic                   update_done,
  output logic                   update_req,
  output logic [FRAME_CNT_W-1:0] frame_id,
  output logic                   busy,
  output logic                   overrun_pulse,
  output logic [OVR_CNT_W-1:0]   overrun_count
`ifdef FRAME_UPDATE_WATCHDOG_EN
  ,
  output logic                   timeout_pulse
`endif
);

  frame_seq_state_t state, state_next;
  logic pending, pending_next;
  logic start, drop;

`ifdef FRAME_UPDATE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_hit;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      frame_id      <= '0;
      overrun_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      pending       <= pending_next;
      overrun_pulse <= drop;
      if (start) frame_id <= frame_id + FRAME_CNT_W'(1);
    end
  end

  // In GAP a held pending always starts the next update, so an incoming tick
  // simply re-arms pending and can never be dropped there.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    start        = 1'b0;
    drop         = 1'b0;
`ifdef FRAME_UPDATE_WATCHDOG_EN
    timeout_hit  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (refresh_tick) begin
          state_next = BUSY;
          start      = 1'b1;
        end
      end
      BUSY: begin
        if (update_done) begin
          state_next = GAP;
        end
`ifdef FRAME_UPDATE_WATCHDOG_EN
        else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_next  = GAP;
          timeout_hit = 1'b1;
        end
`endif
        if (refresh_tick) begin
          if (pending) drop = 1'b1;
          else         pending_next = 1'b1;
        end
      end
      GAP: begin
        if (pending || refresh_tick) begin
          state_next = BUSY;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
        if (pending) pending_next = refresh_tick;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    update_req = (state == BUSY);
    busy       = (state != IDLE);
  end

`ifdef FRAME_UPDATE_WATCHDOG_EN
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      wd_cnt        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (state != BUSY) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`endif

  sat_counter #(.W(OVR_CNT_W)) u_overrun_cnt (
    .clk   (clk_50),
    .clr_n (rst_n),
    .inc   (drop),
    .count (overrun_count)
  );

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Directed self-checking bench for frame_update_sequencer (narrow counters to hit wrap/saturation).
module tb_frame_update_sequencer;

  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       refresh_tick = 1'b0;
  logic       update_done = 1'b0;
  logic       update_req;
  logic [1:0] frame_id;
  logic       busy;
  logic       overrun_pulse;
  logic [1:0] overrun_count;
`ifdef FRAME_UPDATE_WATCHDOG_EN
  logic       timeout_pulse;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk_50 = ~clk_50;

  frame_update_sequencer #(
    .FRAME_CNT_W    (2),
    .OVR_CNT_W      (2),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk_50        (clk_50),
    .rst_n         (rst_n),
    .refresh_tick  (refresh_tick),
    .update_done   (update_done),
    .update_req    (update_req),
    .frame_id      (frame_id),
    .busy          (busy),
    .overrun_pulse (overrun_pulse),
    .overrun_count (overrun_count)
`ifdef FRAME_UPDATE_WATCHDOG_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present tick/done for one posedge, then sample 1 time unit after it.
  task automatic cyc(input logic tick, input logic done);
    refresh_tick = tick;
    update_done  = done;
    @(posedge clk_50);
    #1;
    refresh_tick = 1'b0;
    update_done  = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic req, input logic bsy);
    check({tag, "_req"}, 32'(update_req), 32'(req));
    check({tag, "_busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_fid [5];
    exp_fid = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset: all outputs zero, then idle with no tick
    do_reset();
    check_state("rst", 1'b0, 1'b0);
    check("rst_fid", 32'(frame_id), 0);
    check("rst_ovp", 32'(overrun_pulse), 0);
    check("rst_ovc", 32'(overrun_count), 0);
    repeat (3) cyc(1'b0, 1'b0);
    check_state("idle_hold", 1'b0, 1'b0);

    // Single update: tick -> req with frame_id 1, done -> GAP -> IDLE
    cyc(1'b1, 1'b0);
    check_state("t2_busy", 1'b1, 1'b1);
    check("t2_fid", 32'(frame_id), 1);
    repeat (4) cyc(1'b0, 1'b0);
    check_state("t2_hold", 1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    check_state("t2_gap", 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("t2_idle", 1'b0, 1'b0);

    // Done outside BUSY is ignored
    cyc(1'b0, 1'b1);
    check_state("done_idle", 1'b0, 1'b0);

    // Tick during BUSY is buffered and starts the next update after GAP
    cyc(1'b1, 1'b0);
    check("t3_fid_a", 32'(frame_id), 2);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("t3_ovp_a", 32'(overrun_pulse), 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check_state("t3_gap", 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("t3_busy2", 1'b1, 1'b1);
    check("t3_fid_b", 32'(frame_id), 3);
    check("t3_ovc", 32'(overrun_count), 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("t3_idle", 1'b0, 1'b0);

    // Three ticks in one BUSY: one pending, one dropped; frame_id wraps 3 -> 0
    cyc(1'b1, 1'b0);
    check("t4_fid_wrap", 32'(frame_id), 0);
    cyc(1'b1, 1'b0);
    check("t4_ovp_pend", 32'(overrun_pulse), 0);
    cyc(1'b1, 1'b0);
    check("t4_ovp_drop", 32'(overrun_pulse), 1);
    check("t4_ovc_1", 32'(overrun_count), 1);
    cyc(1'b0, 1'b0);
    check("t4_ovp_once", 32'(overrun_pulse), 0);
    check("t4_ovc_hold", 32'(overrun_count), 1);
    // Four more drops: 2, 3, then saturation at 3
    repeat (4) cyc(1'b1, 1'b0);
    check("t4_ovc_sat", 32'(overrun_count), 3);
    cyc(1'b0, 1'b1);
    check_state("t4_gap", 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("t4_pend_busy", 1'b1, 1'b1);
    check("t4_fid_pend", 32'(frame_id), 1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("t4_idle", 1'b0, 1'b0);

    // GAP with pending and tick: pending consumed, tick re-arms it, nothing dropped
    cyc(1'b1, 1'b0);
    check("gp_fid_a", 32'(frame_id), 2);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check_state("gp_gap", 1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check_state("gp_busy", 1'b1, 1'b1);
    check("gp_fid_b", 32'(frame_id), 3);
    check("gp_ovp", 32'(overrun_pulse), 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("gp_rearm", 1'b1, 1'b1);
    check("gp_fid_c", 32'(frame_id), 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("gp_idle", 1'b0, 1'b0);

    // Done and tick together in BUSY: tick becomes pending
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check_state("dt_gap", 1'b0, 1'b1);
    check("dt_ovp", 32'(overrun_pulse), 0);
    cyc(1'b0, 1'b0);
    check_state("dt_busy", 1'b1, 1'b1);
    check("dt_fid", 32'(frame_id), 2);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("dt_idle", 1'b0, 1'b0);

    // After reset, five updates give frame_id 1,2,3,0,1
    do_reset();
    check("t5_rst_fid", 32'(frame_id), 0);
    check("t5_rst_ovc", 32'(overrun_count), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      check($sformatf("t5_fid%0d", i), 32'(frame_id), 32'(exp_fid[i]));
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
    end
    check_state("t5_idle", 1'b0, 1'b0);

    // Reset during BUSY with a pending tick: req drops, pending is cleared
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    check_state("rb_rst", 1'b0, 1'b0);
    check("rb_fid", 32'(frame_id), 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    check_state("rb_idle", 1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("rb_fid1", 32'(frame_id), 1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check_state("rb_no_pend", 1'b0, 1'b0);

`ifdef FRAME_UPDATE_WATCHDOG_EN
    // Watchdog: no done, abort to GAP 10 cycles after BUSY entry, then IDLE
    cyc(1'b1, 1'b0);
    check("wd_pulse0", 32'(timeout_pulse), 0);
    repeat (9) cyc(1'b0, 1'b0);
    check_state("wd_before", 1'b1, 1'b1);
    check("wd_pulse_pre", 32'(timeout_pulse), 0);
    cyc(1'b0, 1'b0);
    check("wd_pulse", 32'(timeout_pulse), 1);
    check_state("wd_gap", 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check("wd_pulse_end", 32'(timeout_pulse), 0);
    check_state("wd_idle", 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
